// File: rtl/luma_line_buffer.sv
// rtl/luma_line_buffer.sv - ping-pong luma line buffer between pixel source and stateControl
// Writer fills one bank per line; line_start swaps banks only when the write line is complete.

module luma_line_buffer #(
    parameter int                 H_PIXELS    = 256,
    parameter int                 DATA_W      = 8,
    parameter int                 ADDR_W      = 8,
    parameter logic [DATA_W-1:0]  BLACK_LEVEL = DATA_W'(77)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_last_i,
    input  logic              line_start_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [ADDR_W:0]   fill_count_o,
    output logic              underrun_o
);

    typedef enum logic {FILL, DONE} wstate_e;

    localparam logic [ADDR_W:0] H_MAX = (ADDR_W+1)'(H_PIXELS);

    logic [DATA_W-1:0] mem_q [2*H_PIXELS];
    logic [ADDR_W:0]   rlen_q [2];
    wstate_e           state_q;
    logic              wbank_q;
    logic [ADDR_W:0]   fill_q;
    logic [ADDR_W:0]   rptr_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              underrun_q;

    logic              rbank;
    logic              beat;
    logic              complete;
    logic              swap;
    logic [ADDR_W:0]   fill_d;
    logic [ADDR_W:0]   rptr_d;
    logic [ADDR_W:0]   rlen_rd;
    logic [ADDR_W:0]   waddr;
    logic [ADDR_W:0]   raddr;

    assign rbank      = ~wbank_q;
    assign wr_ready_o = (state_q == FILL);
    assign beat       = wr_valid_i & wr_ready_o;
    assign fill_d     = fill_q + 1'b1;
    assign rptr_d     = rptr_q + 1'b1;
    assign complete   = beat & (wr_last_i | (fill_d == H_MAX));
    // A line finishing in the very cycle of line_start still counts as complete.
    assign swap       = line_start_i & ((state_q == DONE) | complete);
    assign rlen_rd    = rlen_q[rbank];
    assign waddr      = {wbank_q, fill_q[ADDR_W-1:0]};
    assign raddr      = {rbank, rptr_q[ADDR_W-1:0]};

    assign rd_data_o    = rd_data_q;
    assign fill_count_o = fill_q;
    assign underrun_o   = underrun_q;

    always_ff @(posedge clk_i) begin
        if (beat) begin
            mem_q[waddr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= FILL;
            wbank_q    <= 1'b0;
            rlen_q[0]  <= '0;
            rlen_q[1]  <= '0;
            fill_q     <= '0;
            rptr_q     <= '0;
            rd_data_q  <= BLACK_LEVEL;
            underrun_q <= 1'b0;
        end else begin
            if (beat) begin
                fill_q <= fill_d;
                if (complete) begin
                    rlen_q[wbank_q] <= fill_d;
                    state_q         <= DONE;
                end
            end

            if (line_start_i) begin
                rptr_q <= '0;
                if (swap) begin
                    wbank_q <= ~wbank_q;
                    fill_q  <= '0;
                    state_q <= FILL;
                end else begin
                    underrun_q <= 1'b1;
                end
            end else if (rd_en_i) begin
                if (rptr_q < rlen_rd) begin
                    rd_data_q <= mem_q[raddr];
                    rptr_q    <= rptr_d;
                end else begin
                    rd_data_q <= BLACK_LEVEL;
                end
            end
        end
    end

endmodule

// File: tb/tb_luma_line_buffer.sv
// tb/tb_luma_line_buffer.sv - self-checking bench for luma_line_buffer
// Reads push expected luma into a scoreboard queue, popped once the registered output is valid.

module tb_luma_line_buffer;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_data;
    logic        wr_last;
    logic        line_start;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic [8:0]  fill_count;
    logic        underrun;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb [$];

    typedef struct {
        logic       wen;
        logic [7:0] wdata;
        logic       wlast;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t tbl [6];

    luma_line_buffer #(
        .H_PIXELS(256), .DATA_W(8), .ADDR_W(8), .BLACK_LEVEL(8'd77)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .wr_valid_i   (wr_valid),
        .wr_ready_o   (wr_ready),
        .wr_data_i    (wr_data),
        .wr_last_i    (wr_last),
        .line_start_i (line_start),
        .rd_en_i      (rd_en),
        .rd_data_o    (rd_data),
        .fill_count_o (fill_count),
        .underrun_o   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_ls();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic wr_px(input logic [7:0] d, input logic l);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = l;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic rd_px(input string name, input logic [7:0] e);
        sb.push_back(e);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            chk(name, rd_data, sb.pop_front());
        end
    endtask

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
        line_start = 1'b0; rd_en = 1'b0;

        tbl[0] = '{1'b1, 8'd10, 1'b0, 8'd10};
        tbl[1] = '{1'b1, 8'd20, 1'b0, 8'd20};
        tbl[2] = '{1'b1, 8'd30, 1'b0, 8'd30};
        tbl[3] = '{1'b1, 8'd40, 1'b1, 8'd40};
        tbl[4] = '{1'b0, 8'd0,  1'b0, 8'd77};
        tbl[5] = '{1'b0, 8'd0,  1'b0, 8'd77};

        // 1: empty buffer outputs black, line_start without a full line flags underrun
        do_reset();
        chk("rst_rd_data", rd_data, 77);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_fill_count", fill_count, 0);
        chk("rst_underrun", underrun, 0);
        pulse_ls();
        chk("t1_underrun", underrun, 1);
        pulse_ls();
        pulse_ls();
        for (int i = 0; i < 10; i++) rd_px("t1_rd", 8'd77);

        // 2: full 256-pixel line
        for (int i = 0; i < 256; i++) wr_px(8'(i), (i == 255));
        chk("t2_fill_full", fill_count, 256);
        chk("t2_ready_done", wr_ready, 0);
        pulse_ls();
        chk("t2_fill_swap", fill_count, 0);
        chk("t2_ready_swap", wr_ready, 1);
        for (int i = 0; i < 256; i++) rd_px("t2_rd", 8'(i));
        rd_px("t2_rd_tail", 8'd77);
        rd_px("t2_rd_tail", 8'd77);

        // 3: short line from vector table
        do_reset();
        chk("t3_underrun_clr", underrun, 0);
        foreach (tbl[i]) if (tbl[i].wen) wr_px(tbl[i].wdata, tbl[i].wlast);
        chk("t3_fill", fill_count, 4);
        chk("t3_ready_done", wr_ready, 0);
        pulse_ls();
        chk("t3_ready_swap", wr_ready, 1);
        foreach (tbl[i]) rd_px("t3_rd", tbl[i].exp_rd);

        // 4: incomplete write line -> replay previous line
        wr_px(8'd5, 1'b0);
        wr_px(8'd6, 1'b0);
        chk("t4_fill2", fill_count, 2);
        pulse_ls();
        chk("t4_underrun", underrun, 1);
        chk("t4_fill_kept", fill_count, 2);
        rd_px("t4_replay", 8'd10);
        rd_px("t4_replay", 8'd20);
        wr_px(8'd7, 1'b0);
        chk("t4_fill3", fill_count, 3);

        // 5: wr_last, line_start and rd_en all in one cycle
        wr_valid = 1'b1; wr_data = 8'd8; wr_last = 1'b1;
        line_start = 1'b1; rd_en = 1'b1;
        tick();
        wr_valid = 1'b0; wr_last = 1'b0; line_start = 1'b0; rd_en = 1'b0;
        chk("t5_rd_hold", rd_data, 20);
        chk("t5_fill_swap", fill_count, 0);
        chk("t5_ready", wr_ready, 1);
        rd_px("t5_rd", 8'd5);
        rd_px("t5_rd", 8'd6);
        rd_px("t5_rd", 8'd7);
        rd_px("t5_rd", 8'd8);
        rd_px("t5_rd_tail", 8'd77);

        // 6: asynchronous reset in the middle of a line read
        for (int i = 0; i < 150; i++) wr_px(8'((i * 3 + 1) & 255), (i == 149));
        pulse_ls();
        for (int i = 0; i < 100; i++) rd_px("t6_rd", 8'((i * 3 + 1) & 255));
        wr_px(8'd99, 1'b0);
        rd_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_rd_data", rd_data, 77);
        chk("t6_async_wr_ready", wr_ready, 1);
        chk("t6_async_fill", fill_count, 0);
        chk("t6_async_underrun", underrun, 0);
        rd_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        pulse_ls();
        for (int i = 0; i < 3; i++) rd_px("t6_rd_black", 8'd77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
